multi_strike_detector: RTL and testbench
========================================

Name: multi_strike_detector

Overview:
- Multi-channel, parametrised successor to the single-axis gyro strike detector.
- Per channel:
  - arms when the sample drops below a programmable negative threshold;
  - tracks the peak (most negative) sample while armed;
  - releases with hysteresis;
  - enforces a refractory window after each strike.
- Completed strikes are queued per channel. They leave through one valid/ready output port carrying the channel index and velocity, which feeds the drum sound-trigger logic.

Parameters:
- NUM_CH, 4, number of independent sensor channels.
- DATA_W, 16, signed sample width.
- THRESH, -2500, signed arm threshold; arm when sample < THRESH.
- HYST, 500, release margin; release when sample >= THRESH + HYST.
- REFRACT, 8, valid samples ignored after release before re-arm (0 = none).
- CH_W, $clog2(NUM_CH) (min 1), channel index width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  all channel samples valid this cycle
- samples  in  NUM_CH*DATA_W  signed samples; channel i at [i*DATA_W +: DATA_W]
- ch_enable  in  NUM_CH  per-channel enable; 0 forces channel to IDLE, clears its peak, keeps pending
- strike_valid  out  1  a strike event is presented
- strike_ready  in  1  consumer accepts event when valid && ready
- strike_ch  out  CH_W  channel of presented event
- strike_vel  out  DATA_W  unsigned peak magnitude (-peak)
- armed  out  NUM_CH  channel in ARMED state (debug)
- overflow  out  NUM_CH  sticky: strike lost because channel pending slot was full

Behaviour:
- Reset: one clk edge with rst=1. All FSMs go to IDLE; peak, refract counters, pending, overflow and armed clear to 0. strike_valid=0, strike_ch=0, strike_vel=0.
- Per-channel FSM advances only on valid_in=1, except for the ch_enable=0 override.
- IDLE: sample < THRESH -> ARMED, peak <= sample. Sample == THRESH stays IDLE.
- ARMED: peak <= min(peak, sample) each valid sample. When sample >= THRESH+HYST:
  - post the event with vel = -min(peak, sample). A sample that releases cannot be below peak, so vel = -peak.
  - go to REFRACT with count = REFRACT; if REFRACT = 0, go straight to IDLE.
- ARMED with THRESH <= sample < THRESH+HYST: hold, no event.
- REFRACT: decrement on each valid sample. Leaving at count 1 -> IDLE. The sample that moves the FSM to IDLE is not evaluated for arming.
- Arithmetic:
  - THRESH+HYST is computed in DATA_W+1 bits (no wrap).
  - vel = 0 - peak in DATA_W+1 bits, truncated to unsigned DATA_W. Peak -32768 gives 32768, which is representable.
- Pending slot: one per channel (flag + vel).
  - Posting sets it at the edge after the release sample, so latency is 1 cycle from the release valid_in to strike_valid.
  - If the slot is already full when a new event posts, the new event is dropped and overflow[i] <= 1. The held event is unchanged.
- Output arbitration:
  - strike_valid = OR of pending flags.
  - The lowest-index pending channel is presented combinationally from registers.
  - Selection is stable while strike_valid && !strike_ready only if no lower channel posts meanwhile; lower-index preemption is permitted, and the consumer must not rely on stability.
  - valid && ready clears that channel's slot at the edge.
- Simultaneous accept and post on the same channel in one cycle: the new event is stored, with no overflow.
- ch_enable falling mid-ARMED: the channel returns to IDLE, no event is posted, and any pending event is still delivered.
- rst asserted mid-operation: all state is discarded, including pending events.

Decomposition:
- Package strike_pkg holds:
  - typedef strike_state_t {IDLE, ARMED, REFRACT};
  - default THRESH/HYST/REFRACT constants;
  - a typedef for the event struct {ch, vel}.
- One sub-module, strike_channel: per-channel FSM, peak tracker, refract counter and pending slot, instantiated NUM_CH times via generate.
- The top level holds the priority arbiter and the overflow/armed vectors.

Test Plan:
- Ch0 samples 0, -3000, -4200, -2600, -1900 (ready=1): armed after -3000. Strike_valid 1 cycle after -1900 with ch=0, vel=4200. No event at -2600 (< -2000 release level).
- Ch1 dips to -3000, rises to -2400, dips to -3500, rises to -1000: exactly one event, vel=3500, with no retrigger inside the hysteresis band.
- REFRACT=8: ch2 strike, then a second dip to -5000 on the 4th valid sample after release: ignored. The same dip after 8 samples produces a second event.
- Ch0 and ch3 release on the same sample, ready held 0 for 3 cycles then 1: ch0 is presented first, then ch3 on the next cycle, with both vels correct.
- Ready=0 while ch1 strikes twice: overflow[1]=1, and the first event's vel is retained and delivered when ready rises.
- Sample -32768 then 0 on ch0: vel=32768. Also assert rst while ch2 is ARMED with a pending event: everything clears and no event appears.

Source files
------------

// File: rtl/strike_pkg.sv
// Shared types and default tuning for the multi-channel strike detector.
package strike_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, REFRACT} strike_state_t;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_THRESH  = -2500;
  localparam int DEF_HYST    = 500;
  localparam int DEF_REFRACT = 8;
  localparam int DEF_CH_W    = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;

  typedef struct packed {
    logic [DEF_CH_W-1:0]   ch;
    logic [DEF_DATA_W-1:0] vel;
  } strike_evt_t;

endpackage

// File: rtl/strike_channel.sv
// One sensor channel: arm/peak/release FSM, refractory counter and a
// single-entry pending slot for the completed strike.
module strike_channel
  import strike_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int THRESH  = DEF_THRESH,
  parameter int HYST    = DEF_HYST,
  parameter int REFRACT = DEF_REFRACT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic                     enable_i,
  input  logic                     accept_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic                     pend_o,
  output logic [DATA_W-1:0]        vel_o,
  output logic                     armed_o,
  output logic                     drop_o
);

  localparam int CNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [DATA_W:0] THR_X = (DATA_W+1)'(THRESH);
  localparam logic signed [DATA_W:0] REL_X = THR_X + (DATA_W+1)'(HYST);

  // -peak needs one extra bit so the most negative sample maps to 2^(DATA_W-1)
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] p);
    logic signed [DATA_W:0] neg;
    neg = -$signed({p[DATA_W-1], p});
    return neg[DATA_W-1:0];
  endfunction

  strike_state_t             state_q, state_d;
  logic signed [DATA_W-1:0]  peak_q, peak_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic [DATA_W-1:0]         vel_q, vel_d;
  logic                      post;
  logic                      drop;
  logic [DATA_W-1:0]         vel_new;
  logic signed [DATA_W:0]    sample_x;
  logic signed [DATA_W-1:0]  pmin;

  assign sample_x = {sample_i[DATA_W-1], sample_i};
  assign pmin     = (sample_i < peak_q) ? sample_i : peak_q;

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    post    = 1'b0;
    vel_new = magnitude(pmin);
    if (!enable_i) begin
      state_d = IDLE;
      peak_d  = '0;
      cnt_d   = '0;
    end else if (valid_i) begin
      unique case (state_q)
        IDLE: begin
          if (sample_x < THR_X) begin
            state_d = ARMED;
            peak_d  = sample_i;
          end
        end
        ARMED: begin
          peak_d = pmin;
          if (sample_x >= REL_X) begin
            post = 1'b1;
            if (REFRACT == 0) begin
              state_d = IDLE;
            end else begin
              state_d = strike_pkg::REFRACT;
              cnt_d   = CNT_W'(REFRACT);
            end
          end
        end
        strike_pkg::REFRACT: begin
          // The sample that ends the window is consumed here, never armed on
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pend_d = pend_q;
    vel_d  = vel_q;
    drop   = 1'b0;
    if (accept_i) pend_d = 1'b0;
    // An accept in the same cycle frees the slot for the new event
    if (post) begin
      if (pend_q && !accept_i) begin
        drop = 1'b1;
      end else begin
        pend_d = 1'b1;
        vel_d  = vel_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      peak_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      vel_q   <= '0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      vel_q   <= vel_d;
    end
  end

  assign pend_o  = pend_q;
  assign vel_o   = vel_q;
  assign armed_o = (state_q == ARMED);
  assign drop_o  = drop;

endmodule

// File: rtl/multi_strike_detector.sv
// Multi-channel strike detector: per-channel detectors feeding a
// lowest-index-first valid/ready event port.
module multi_strike_detector
  import strike_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int THRESH  = DEF_THRESH,
  parameter int HYST    = DEF_HYST,
  parameter int REFRACT = DEF_REFRACT,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [NUM_CH*DATA_W-1:0] samples,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic                     strike_valid,
  input  logic                     strike_ready,
  output logic [CH_W-1:0]          strike_ch,
  output logic [DATA_W-1:0]        strike_vel,
  output logic [NUM_CH-1:0]        armed,
  output logic [NUM_CH-1:0]        overflow
);

  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] drop_w;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] accept;
  logic [DATA_W-1:0] vel_w [NUM_CH];
  logic [CH_W-1:0]   sel_ch;
  logic [NUM_CH-1:0] overflow_q, overflow_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    strike_channel #(
      .DATA_W  (DATA_W),
      .THRESH  (THRESH),
      .HYST    (HYST),
      .REFRACT (REFRACT)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_in),
      .enable_i (ch_enable[g]),
      .accept_i (accept[g]),
      .sample_i (samples[g*DATA_W +: DATA_W]),
      .pend_o   (pend_w[g]),
      .vel_o    (vel_w[g]),
      .armed_o  (armed[g]),
      .drop_o   (drop_w[g])
    );
  end

  // Scan high to low so the lowest pending index wins
  always_comb begin
    sel_ch = '0;
    grant  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_w[i]) begin
        sel_ch   = CH_W'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign accept       = grant & {NUM_CH{strike_ready}};
  assign strike_valid = |pend_w;
  assign strike_ch    = sel_ch;
  assign strike_vel   = strike_valid ? vel_w[sel_ch] : '0;

  assign overflow_d = overflow_q | drop_w;

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= '0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_multi_strike_detector.sv
// Directed bench for multi_strike_detector with hand-computed event values.
module tb_multi_strike_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [63:0] samples;
  logic [3:0]  ch_enable;
  logic        strike_valid;
  logic        strike_ready;
  logic [1:0]  strike_ch;
  logic [15:0] strike_vel;
  logic [3:0]  armed;
  logic [3:0]  overflow;

  int checks = 0;
  int errors = 0;

  multi_strike_detector dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .samples      (samples),
    .ch_enable    (ch_enable),
    .strike_valid (strike_valid),
    .strike_ready (strike_ready),
    .strike_ch    (strike_ch),
    .strike_vel   (strike_vel),
    .armed        (armed),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic signed [15:0] s0, input logic signed [15:0] s1,
                      input logic signed [15:0] s2, input logic signed [15:0] s3);
    valid_in = 1'b1;
    samples  = {s3, s2, s1, s0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic chk_evt(input string tag, input logic [1:0] ch, input logic [15:0] vel);
    chk({tag, "_valid"}, strike_valid, 1);
    chk({tag, "_ch"}, strike_ch, ch);
    chk({tag, "_vel"}, strike_vel, vel);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; samples = '0; ch_enable = 4'hF; strike_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_valid", strike_valid, 0);
    chk("rst_ch", strike_ch, 0);
    chk("rst_vel", strike_vel, 0);
    chk("rst_armed", armed, 0);
    chk("rst_ovf", overflow, 0);

    // ch0 basic strike
    step(0, 0, 0, 0);
    step(-3000, 0, 0, 0);      chk("t1_armed", armed, 4'b0001);
    step(-4200, 0, 0, 0);
    step(-2600, 0, 0, 0);      chk("t1_hold_valid", strike_valid, 0);
                               chk("t1_hold_armed", armed, 4'b0001);
    step(-1900, 0, 0, 0);      chk_evt("t1_evt", 0, 4200);
                               chk("t1_disarm", armed, 0);
    step(0, 0, 0, 0);          chk("t1_consumed", strike_valid, 0);

    // ch1 hysteresis band: one event only
    step(0, -3000, 0, 0);      chk("t2_armed", armed, 4'b0010);
    step(0, -2400, 0, 0);      chk("t2_band_valid", strike_valid, 0);
                               chk("t2_band_armed", armed, 4'b0010);
    step(0, -3500, 0, 0);
    step(0, -1000, 0, 0);      chk_evt("t2_evt", 1, 3500);
    step(0, 0, 0, 0);
    idle(3);                   chk("t2_no_retrig", strike_valid, 0);

    // valid_in low must not advance the FSM
    valid_in = 1'b0; samples = {-16'sd9000, 48'd0};
    @(posedge clk); #1;        chk("inv_armed", armed, 0);

    // ch2 refractory window
    step(0, 0, -3000, 0);
    step(0, 0, 0, 0);          chk_evt("t3_evt1", 2, 3000);
    idle(3);
    step(0, 0, -5000, 0);      chk("t3_refr_armed", armed, 0);
                               chk("t3_refr_valid", strike_valid, 0);
    idle(3);
    step(0, 0, -5000, 0);      chk("t3_exit_armed", armed, 0);
    step(0, 0, -5000, 0);      chk("t3_rearm", armed, 4'b0100);
    step(0, 0, 0, 0);          chk_evt("t3_evt2", 2, 5000);
    step(0, 0, 0, 0);

    // ch0 and ch3 release together, ready low for 3 cycles
    step(-3000, 0, 0, -2800);  chk("t4_armed", armed, 4'b1001);
    strike_ready = 1'b0;
    step(0, 0, 0, 0);          chk_evt("t4_first", 0, 3000);
    idle(2);                   chk_evt("t4_held", 0, 3000);
    strike_ready = 1'b1;
    step(0, 0, 0, 0);          chk_evt("t4_second", 3, 2800);
    step(0, 0, 0, 0);          chk("t4_drained", strike_valid, 0);
    idle(2);

    // ch2 accept and new post on the same edge
    strike_ready = 1'b0;
    step(0, 0, -3000, 0);
    step(0, 0, 0, 0);          chk_evt("t5_a", 2, 3000);
    idle(8);
    step(0, 0, -4500, 0);      chk("t5_armed", armed, 4'b0100);
    strike_ready = 1'b1;
    step(0, 0, 0, 0);          chk_evt("t5_b", 2, 4500);
                               chk("t5_no_ovf", overflow, 0);
    step(0, 0, 0, 0);          chk("t5_drained", strike_valid, 0);

    // ch1 overflow while ready low
    strike_ready = 1'b0;
    step(0, -3000, 0, 0);
    step(0, 0, 0, 0);          chk_evt("t6_first", 1, 3000);
    idle(8);
    step(0, -4000, 0, 0);
    step(0, 0, 0, 0);          chk("t6_ovf", overflow, 4'b0010);
                               chk_evt("t6_kept", 1, 3000);
    strike_ready = 1'b1;
    step(0, 0, 0, 0);          chk("t6_drained", strike_valid, 0);
                               chk("t6_ovf_sticky", overflow, 4'b0010);

    // most negative sample
    step(-32768, 0, 0, 0);
    step(0, 0, 0, 0);          chk_evt("t7_min", 0, 32768);
    step(0, 0, 0, 0);

    // channel disable drops an armed strike
    step(0, 0, 0, -3000);      chk("t8_armed", armed, 4'b1000);
    ch_enable = 4'b0111;
    step(0, 0, 0, -3000);      chk("t8_disabled", armed, 0);
    ch_enable = 4'hF;
    step(0, 0, 0, 0);          chk("t8_no_evt", strike_valid, 0);

    // reset while ch2 armed with a pending event
    strike_ready = 1'b0;
    step(0, 0, -3000, 0);
    step(0, 0, 0, 0);
    idle(8);
    step(0, 0, -3000, 0);      chk("t9_armed", armed, 4'b0100);
                               chk("t9_pending", strike_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t9_valid", strike_valid, 0);
    chk("t9_armed_clr", armed, 0);
    chk("t9_ovf_clr", overflow, 0);
    chk("t9_vel", strike_vel, 0);
    strike_ready = 1'b1;
    step(0, 0, 0, 0);          chk("t9_no_evt", strike_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
